// File: rtl/encoder_sched.sv
// ---------------------------------------------------------------------------
// encoder_sched
//   Sequencer for the LDPC generator-matrix encoder datapath. For every
//   codeword column n it reads all SLICES slices of G^T column n, together
//   with the matching info-bit slices. It then folds the AND-parity of each
//   slice pair into one code bit. Code bits are packed into DATA_WIDTH-bit
//   words and offered downstream on a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         begin one block (sampled in IDLE only)
//   g_rd_en       read strobe to G^T ROM and info RAM
//   g_col_addr    column index n
//   g_slice_addr  slice index s (also the info RAM address)
//   g_rdata       G^T slice, valid 1 cycle after g_rd_en
//   info_rdata    info slice, valid 1 cycle after g_rd_en
//   cw_data       packed code word (bit n mod DATA_WIDTH of word n/DATA_WIDTH)
//   cw_valid      cw_data valid (EMIT only)
//   cw_ready      downstream accepts
//   cw_last       final word of the block
//   busy          any state except IDLE
//   done          one-cycle completion pulse
//
// Handshake: a word transfers on a rising edge where cw_valid and cw_ready
// are both high; while cw_valid is high and cw_ready is low, cw_data and
// cw_last hold their values and no reads are issued.
// ---------------------------------------------------------------------------
module encoder_sched #(
  parameter int N              = 2304,
  parameter int K              = 1536,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_BITS_N     = 12,
  parameter int MAX_BITS_SLICE = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      g_rd_en,
  output logic [MAX_BITS_N-1:0]     g_col_addr,
  output logic [MAX_BITS_SLICE-1:0] g_slice_addr,
  input  logic [DATA_WIDTH-1:0]     g_rdata,
  input  logic [DATA_WIDTH-1:0]     info_rdata,
  output logic [DATA_WIDTH-1:0]     cw_data,
  output logic                      cw_valid,
  input  logic                      cw_ready,
  output logic                      cw_last,
  output logic                      busy,
  output logic                      done
);

  localparam int SLICES = K / DATA_WIDTH;
  // DATA_WIDTH is a power of two, so n mod DATA_WIDTH is the low bits of n.
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [MAX_BITS_N-1:0]     N_LAST     = MAX_BITS_N'(N - 1);
  localparam logic [MAX_BITS_SLICE-1:0] SLICE_LAST = MAX_BITS_SLICE'(SLICES - 1);
  localparam logic [BIT_W-1:0]          BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [MAX_BITS_N-1:0]     n_q, n_d;
  logic [MAX_BITS_SLICE-1:0] s_q, s_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      rd_last_q, rd_last_d;
  logic [BIT_W-1:0]          rd_bit_q, rd_bit_d;
  logic                      acc_q, acc_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic                      last_word_q, last_word_d;
  logic                      parity;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    s_d         = s_q;
    acc_d       = acc_q;
    word_d      = word_q;
    last_word_d = last_word_q;

    // Read pipeline: tag each issued read so the returning data knows
    // whether it closes a column and which word bit it belongs to.
    rd_vld_d  = (state_q == ST_RUN);
    rd_last_d = (state_q == ST_RUN) && (s_q == SLICE_LAST);
    rd_bit_d  = n_q[BIT_W-1:0];

    parity = ^(g_rdata & info_rdata);
    if (rd_vld_q) begin
      if (rd_last_q) begin
        word_d[rd_bit_q] = acc_q ^ parity;
        acc_d            = 1'b0;
      end else begin
        acc_d = acc_q ^ parity;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          n_d         = '0;
          s_d         = '0;
          last_word_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (s_q == SLICE_LAST) begin
          s_d = '0;
          n_d = (n_q == N_LAST) ? '0 : n_q + 1'b1;
          // Column closing a word: stop issuing so the word can drain.
          if (n_q[BIT_W-1:0] == BIT_LAST) begin
            state_d     = ST_DRAIN;
            last_word_d = (n_q == N_LAST);
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT: begin
        if (cw_ready) begin
          word_d  = '0;
          state_d = last_word_q ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      s_q         <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_bit_q    <= '0;
      acc_q       <= 1'b0;
      word_q      <= '0;
      last_word_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      s_q         <= s_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      rd_bit_q    <= rd_bit_d;
      acc_q       <= acc_d;
      word_q      <= word_d;
      last_word_q <= last_word_d;
    end
  end

  // Outputs decode from state so an asynchronous reset zeroes them at once.
  assign g_rd_en      = (state_q == ST_RUN);
  assign g_col_addr   = g_rd_en ? n_q : '0;
  assign g_slice_addr = g_rd_en ? s_q : '0;
  assign cw_valid     = (state_q == ST_EMIT);
  assign cw_data      = cw_valid ? word_q : '0;
  assign cw_last      = cw_valid & last_word_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_encoder_sched.sv
// ---------------------------------------------------------------------------
// tb_encoder_sched
//   Directed bench for encoder_sched in the small configuration
//   (N=32, K=32, DATA_WIDTH=16). Behavioural G^T ROM and info RAM with
//   one-cycle read latency feed the DUT. Cycle 0 is the cycle in which start
//   is sampled, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_encoder_sched;

  localparam int N  = 32;
  localparam int K  = 32;
  localparam int DW = 16;
  localparam int BN = 5;
  localparam int BS = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          g_rd_en;
  logic [BN-1:0] g_col_addr;
  logic [BS-1:0] g_slice_addr;
  logic [DW-1:0] g_rdata;
  logic [DW-1:0] info_rdata;
  logic [DW-1:0] cw_data;
  logic          cw_valid;
  logic          cw_ready;
  logic          cw_last;
  logic          busy;
  logic          done;

  encoder_sched #(
    .N(N), .K(K), .DATA_WIDTH(DW), .MAX_BITS_N(BN), .MAX_BITS_SLICE(BS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .g_rd_en(g_rd_en), .g_col_addr(g_col_addr), .g_slice_addr(g_slice_addr),
    .g_rdata(g_rdata), .info_rdata(info_rdata),
    .cw_data(cw_data), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .cw_last(cw_last), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memories with one-cycle latency
  logic [DW-1:0] g_mem [0:N-1][0:1];
  logic [DW-1:0] info_mem [0:1];

  initial begin
    g_rdata    = '0;
    info_rdata = '0;
  end

  always @(posedge clk) begin
    if (g_rd_en) begin
      g_rdata    <= g_mem[g_col_addr][g_slice_addr];
      info_rdata <= info_mem[g_slice_addr];
    end
  end

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          last_q[$];
  int            done_cyc;
  int            done_cnt;
  int            rd_cnt;
  int            addr_bad;
  int            stall_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // c = u * G mod 2, one column at a time
  function automatic logic [DW-1:0] model_word(input int w);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < DW; b++) begin
      r[b] = ^(g_mem[w*DW+b][0] & info_mem[0]) ^ ^(g_mem[w*DW+b][1] & info_mem[1]);
    end
    return r;
  endfunction

  task automatic fill_random_g();
    for (int n = 0; n < N; n++) begin
      g_mem[n][0] = DW'($urandom_range(0, 65535));
      g_mem[n][1] = DW'($urandom_range(0, 65535));
    end
  endtask

  task automatic load_model();
    exp_q.delete();
    exp_q.push_back(model_word(0));
    exp_q.push_back(model_word(1));
  endtask

  // Drive one block. stall_n: cycles of cw_ready low on the first word;
  // again_cyc: cycle at which start is pulsed again; abort_cyc: cycle at
  // which rst is pulled low (-1 disables each).
  task automatic run_block(input int stall_n, input int again_cyc, input int abort_cyc);
    logic [DW-1:0] hold;
    int stalled;
    got_q.delete();
    last_q.delete();
    done_cyc  = -1;
    done_cnt  = 0;
    rd_cnt    = 0;
    addr_bad  = 0;
    stall_bad = 0;
    stalled   = 0;
    hold      = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == abort_cyc) begin
        rst = 1'b0;
        #1;
        chk("abort_outputs",
            {g_rd_en, g_col_addr, g_slice_addr, cw_valid, cw_last, busy, done, cw_data},
            32'h0);
        break;
      end
      start = (cyc == again_cyc);
      if (g_rd_en) begin
        if (g_col_addr != BN'(rd_cnt / 2) || g_slice_addr != BS'(rd_cnt % 2)) addr_bad++;
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cw_valid) begin
        if (got_q.size() == 0 && stalled > 0 && cw_data != hold) stall_bad++;
        if (got_q.size() == 0 && stalled < stall_n) begin
          if (stalled == 0) hold = cw_data;
          cw_ready = 1'b0;
          stalled++;
        end else begin
          cw_ready = 1'b1;
          got_q.push_back(cw_data);
          last_q.push_back(cw_last);
        end
      end else begin
        if (cw_ready == 1'b0 && g_rd_en) stall_bad++;
        cw_ready = 1'b1;
      end
      if (cw_ready == 1'b0 && g_rd_en) stall_bad++;
      if (done_cnt > 0 && cyc > done_cyc + 3) break;
    end
    start = 1'b0;
    cw_ready = 1'b1;
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_word"}, got_q[i], exp_q[i]);
      chk({tag, "_last"}, last_q[i], (i == exp_q.size() - 1) ? 1 : 0);
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    cw_ready = 1'b1;
    for (int n = 0; n < N; n++) begin
      g_mem[n][0] = '0;
      g_mem[n][1] = '0;
    end
    info_mem[0] = '0;
    info_mem[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {g_rd_en, g_col_addr, g_slice_addr, cw_valid, cw_last, busy, done, cw_data}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // all-zero info, random G
    fill_random_g();
    exp_q.delete();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    run_block(0, -1, -1);
    check_words("zero");
    chk("zero_done_cyc", done_cyc, 69);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_idle_after", busy, 0);

    // single info bit selects G^T slice0 bit0 = n[0]
    fill_random_g();
    for (int n = 0; n < N; n++) g_mem[n][0][0] = n[0];
    info_mem[0] = 16'h0001;
    info_mem[1] = 16'h0000;
    exp_q.delete();
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'hAAAA);
    run_block(0, -1, -1);
    check_words("alt");

    // random info and G against the matrix model
    fill_random_g();
    info_mem[0] = DW'($urandom_range(0, 65535));
    info_mem[1] = DW'($urandom_range(0, 65535));
    load_model();
    run_block(0, -1, -1);
    check_words("rand");
    chk("rand_rd_cnt", rd_cnt, 64);
    chk("rand_addr_seq", addr_bad, 0);
    chk("rand_done_cyc", done_cyc, 69);

    // backpressure on the first word
    fill_random_g();
    info_mem[0] = DW'($urandom_range(0, 65535));
    info_mem[1] = DW'($urandom_range(0, 65535));
    load_model();
    run_block(5, -1, -1);
    check_words("stall");
    chk("stall_hold", stall_bad, 0);
    chk("stall_done_cyc", done_cyc, 74);
    chk("stall_rd_cnt", rd_cnt, 64);

    // start while busy is ignored
    run_block(0, 10, -1);
    check_words("restart");
    chk("restart_done_cnt", done_cnt, 1);
    chk("restart_rd_cnt", rd_cnt, 64);

    // reset mid-block, then a fresh block
    run_block(0, -1, 20);
    chk("abort_done_cnt", done_cnt, 0);
    repeat (2) @(negedge clk);
    chk("abort_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    fill_random_g();
    info_mem[0] = DW'($urandom_range(0, 65535));
    info_mem[1] = DW'($urandom_range(0, 65535));
    load_model();
    run_block(0, -1, -1);
    check_words("fresh");
    chk("fresh_addr_seq", addr_bad, 0);
    chk("fresh_done_cyc", done_cyc, 69);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encoder_sched.md
Name: encoder_sched

Overview:
- Sequencer for the LDPC generator-matrix encoder datapath.
- Walks every codeword column n (0..N-1) and every DATA_WIDTH-bit slice s (0..SLICES-1) of the transposed generator matrix. Issues matched addresses to the G^T ROM and the info-bit RAM.
- Mod-2 accumulates AND-parity of each returned slice pair into one code bit per column.
- Packs code bits into DATA_WIDTH-bit words and hands them downstream on a valid/ready handshake.

Parameters:
- N, 2304, codeword length (columns of G^T); must be a multiple of DATA_WIDTH.
- K, 1536, info length; must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 16, slice and output word width.
- MAX_BITS_N, 12, ceil(log2(N)).
- MAX_BITS_SLICE, 7, ceil(log2(K/DATA_WIDTH)); SLICES = K/DATA_WIDTH = 96.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin encoding one block; sampled only in IDLE.
- g_rd_en  out  1  read strobe to G^T ROM and info RAM.
- g_col_addr  out  MAX_BITS_N  column index n.
- g_slice_addr  out  MAX_BITS_SLICE  slice index s; also the info RAM address.
- g_rdata  in  DATA_WIDTH  G^T slice; valid exactly 1 cycle after g_rd_en.
- info_rdata  in  DATA_WIDTH  info-bit slice; valid exactly 1 cycle after g_rd_en.
- cw_data  out  DATA_WIDTH  packed code bits; code bit n sits at bit (n mod DATA_WIDTH) of word n/DATA_WIDTH.
- cw_valid  out  1  cw_data valid.
- cw_ready  in  1  downstream accepts.
- cw_last  out  1  high with the final word of the block.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at block completion.

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0. Counters, accumulator and word register cleared. A reset mid-block aborts it; no done pulse.
- States: IDLE, RUN, DRAIN, EMIT, DONE.
- IDLE:
  - start=1 -> RUN next cycle, with n=0, s=0.
  - start is ignored in every other state.
- RUN:
  - g_rd_en=1 every cycle, with addresses (n, s).
  - s increments and wraps at SLICES-1, at which point n increments.
  - After issuing the last slice of a column with n mod DATA_WIDTH == DATA_WIDTH-1 -> DRAIN. No address is issued in DRAIN/EMIT.
- Read pipeline:
  - rd_vld and rd_last (last slice) are g_rd_en and (s==SLICES-1) delayed 1 cycle.
  - On rd_vld: p = XOR-reduce(g_rdata & info_rdata).
  - If rd_last: code bit = acc ^ p, written to word bit; acc <= 0.
  - Otherwise: acc <= acc ^ p.
- DRAIN: one cycle; the final slice result lands in the word register. Then -> EMIT.
- EMIT:
  - cw_valid=1; cw_data and cw_last are held stable until cw_ready=1.
  - On accept: word register cleared. If it was the last word -> DONE, else -> RUN, resuming at the next column.
  - cw_last=1 only on word N/DATA_WIDTH-1.
- DONE: done=1 for one cycle, busy=1, then -> IDLE.
- Timing with cw_ready held high, start at cycle 0:
  - Each word takes DATA_WIDTH*SLICES+2 cycles.
  - done is high at cycle 1 + (N/DATA_WIDTH)*(DATA_WIDTH*SLICES+2); default = 221473.
- Backpressure: cw_ready low stalls in EMIT indefinitely; no reads are issued and no state changes.
- cw_valid is never asserted outside EMIT.
- Width rules:
  - acc is 1 bit.
  - Counters are sized exactly by MAX_BITS_N/MAX_BITS_SLICE and compared against N-1 and SLICES-1.
  - No out-of-range address is ever driven.

Test Plan (small config N=32, K=32, DATA_WIDTH=16, MAX_BITS_N=5, MAX_BITS_SLICE=1; ROM/RAM behavioural models with 1-cycle latency):
- All-zero info RAM, random G -> two words 16'h0000, 16'h0000; cw_last on the second; done at cycle 69.
- Info = 32'h0000_0001 (slice0 bit0 = 1); G^T column n slice0 bit0 = n[0] -> words 16'hAAAA, 16'hAAAA.
- Random info and G, cw_ready tied high -> words match a software model of c = u·G mod 2; g_rd_en high for exactly 64 cycles total; addresses follow the sequence (0,0),(0,1),(1,0)…(31,1).
- cw_ready low for 5 cycles on the first word -> cw_data stable, cw_valid held, g_rd_en=0 throughout; done delayed by exactly 5 cycles (cycle 74).
- start pulsed again at cycle 10 while busy -> ignored; a single block completes with exactly 2 output words.
- rst low at cycle 20 -> all outputs 0 immediately; no done pulse. A fresh start afterwards produces a correct block from column 0.
